// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default clock/baud settings
// used by the receiver, transmitter and command parser.
package uart_pkg;

  localparam int CLK_HZ_DEF = 50_000_000;
  localparam int BAUD_DEF   = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset
// to 1 so an idle-high serial line is not mistaken for a start bit.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples the start bit at mid-bit, then each data and
// stop bit one bit period later, and reports a good byte or a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int BAUD   = BAUD_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  uart_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rx_data_n;
  logic          new_n, ferr_n;
  logic          rx_s, rx_prev;

  sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      rx_data     <= '0;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
      rx_prev     <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      rx_data     <= rx_data_n;
      new_rx_data <= new_n;
      frame_err   <= ferr_n;
      rx_prev     <= rx_s;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    rx_data_n = rx_data;
    new_n     = 1'b0;
    ferr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        // Only a high-to-low transition starts a frame, so a line held low
        // (after reset or a framing error) is never read as a new start bit.
        if (rx_prev && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == DIV_M1) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == DIV_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            rx_data_n = shift;
            new_n     = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames on the serial line, checked against a
// frame-level model of expected bytes, framing errors and held rx_data.
module tb_uart_rx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115_200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int LAT    = 2 + HALF + 9 * DIV;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] rx_data;
  logic       new_rx_data, frame_err, busy;

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx          (rx),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int n_new = 0;
  int n_ferr = 0;
  int last_fall = 0;
  logic [7:0] got_q[$];
  int         pulse_cyc_q[$];
  logic [7:0] prev_data;
  logic       rstn_prev;

  // reference model state
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (new_rx_data === 1'b1) begin
      n_new++;
      got_q.push_back(rx_data);
      pulse_cyc_q.push_back(cyc);
    end
    if (frame_err === 1'b1) n_ferr++;
    if (new_rx_data === 1'b1 || frame_err === 1'b1)
      chk("pulse_excl", {31'd0, new_rx_data & frame_err}, 32'd0);
    if (rstn === 1'b1 && rstn_prev === 1'b1 && rx_data !== prev_data)
      chk("data_hold", {31'd0, new_rx_data}, 32'd1);
    prev_data = rx_data;
    rstn_prev = rstn;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    last_fall = cyc;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = stop_bit;
    tick(DIV);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic verify(input string tag);
    chk({tag, "_count"}, n_new, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_data"}, (i < got_q.size()) ? {24'd0, got_q[i]} : 32'bx, {24'd0, exp_q[i]});
    chk({tag, "_ferr"}, n_ferr, exp_ferr);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_data});
    exp_q.delete();
    exp_ferr = 0;
    n_new = 0;
    n_ferr = 0;
    got_q.delete();
    pulse_cyc_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int lat;
    int busy_hi;
    int gap;
    logic prev_bad;
    logic [7:0] b;
    logic sb;

    rstn = 1'b0;
    rx   = 1'b1;
    tick(3);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_new", {31'd0, new_rx_data}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    tick(5);
    n_new = 0; n_ferr = 0; got_q.delete(); pulse_cyc_q.delete();

    // single byte with latency window
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    tick(DIV);
    lat = (pulse_cyc_q.size() > 0) ? pulse_cyc_q[0] - last_fall : -1;
    ncmp++;
    assert (lat >= LAT - 2 && lat <= LAT + 2) else begin
      nfail++;
      $error("FAIL lat_55: observed %0d expected %0d +/-2", lat, LAT);
    end
    verify("b55");

    // short low glitch is rejected at the start-bit sample
    rx = 1'b0;
    last_fall = cyc;
    tick(50);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    tick(50);
    rx = 1'b1;
    tick(130);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    tick(DIV);
    verify("glitch");

    // stop bit low
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    rx = 1'b1;
    tick(DIV);
    verify("ferr");

    // back-to-back frames, no idle bit
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    model_frame(8'hA3, 1'b1);
    model_frame(8'h00, 1'b1);
    tick(DIV);
    verify("b2b");

    // reset during bit 4 abandons the frame
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    tick(DIV);
    verify("pre81");
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick(5 * DIV + 200);
        rstn = 1'b0;
        tick(3);
        chk("rst_mid_data", {24'd0, rx_data}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        exp_data = 8'h00;
        rstn = 1'b1;
      end
    join
    tick(DIV);
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    tick(DIV);
    verify("rst81");

    // single byte then long idle
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1);
    busy_hi = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (busy !== 1'b0) busy_hi++;
    end
    chk("idle_busy", busy_hi, 32'd0);
    verify("ff");

    // randomized frames with random gaps and occasional bad stop bits
    prev_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b   = 8'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      gap = prev_bad ? DIV + $urandom_range(0, DIV) : $urandom_range(0, 2) * $urandom_range(0, DIV);
      rx  = 1'b1;
      if (gap > 0) tick(gap);
      send_frame(b, sb);
      model_frame(b, sb);
      prev_bad = !sb;
    end
    rx = 1'b1;
    tick(DIV);
    verify("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 rx_data  output  8  last correctly framed byte received; held stable until the next good byte.
REQ-007 new_rx_data  output  1  one-cycle pulse; rx_data is valid in the same cycle.
REQ-008 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 busy  output  1  high in every state other than IDLE.

Function
REQ-010 The block SHALL pass rx through a two-flop synchronizer, reset to 1, before any use; the synchronized signal is rx_s.
REQ-011 DIV SHALL equal CLK_HZ/BAUD with integer truncation (434 at defaults), and HALF SHALL equal DIV/2 (217).
REQ-012 The baud counter SHALL be wide enough for DIV-1 and SHALL clear to 0 on every state entry and after every sample.
REQ-013 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-014 IDLE: rx_s==0 SHALL move the FSM to START with counter=0.
REQ-015 START: at counter==HALF-1 the block SHALL sample rx_s.
  - 0: go to DATA, bit index=0.
  - 1: go to IDLE, treated as a glitch, no output pulse.
REQ-016 DATA: at counter==DIV-1 the block SHALL sample rx_s into shift register bit [index], LSB first.
  - After index 7 is sampled, go to STOP.
REQ-017 STOP: at counter==DIV-1 the block SHALL sample rx_s and go to IDLE in the same cycle, so a back-to-back start bit is accepted without an idle gap.
REQ-018 If the stop sample is 1, rx_data SHALL load the shift register and new_rx_data SHALL pulse for exactly one cycle, registered with rx_data.
REQ-019 If the stop sample is 0, frame_err SHALL pulse for one cycle, rx_data SHALL keep its previous value, and new_rx_data SHALL stay low.
REQ-020 new_rx_data and frame_err SHALL never be high in the same cycle.
REQ-021 From the first low rx edge to the new_rx_data rising edge, latency SHALL be 2 + HALF + 9*DIV clock cycles, ±2.
REQ-022 While not IDLE, rx activity SHALL have no effect except at the sample points.

Reset
REQ-023 When rstn==0 at a rising clk edge, the block SHALL set:
  - state=IDLE, counter=0, bit index=0, shift=0x00, rx_data=0x00
  - new_rx_data=0, frame_err=0, busy=0
  - synchronizer flops=1
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no pulse output.
REQ-025 After reset releases, reception SHALL restart only on a fresh falling edge of rx_s.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state encoding (2-bit localparams IDLE=0, START=1, DATA=2, STOP=3) and the default CLK_HZ and BAUD values.
REQ-027 The package SHALL be shared with the transmitter and cmd_parser.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, rstn, d and q, and reset value 1.
REQ-029 All other logic SHALL reside in uart_rx.

Verification
REQ-030 The bench SHALL use defaults (DIV=434) and drive rx with ideal 434-cycle bits.
REQ-031 Byte 0x55 -> one new_rx_data pulse, rx_data=0x55, frame_err=0, within the REQ-021 latency window.
REQ-032 Bytes 0xA3 then 0x00 back-to-back with no idle bit -> two pulses, rx_data=0xA3 then 0x00.
REQ-033 rx low for 100 cycles, then high -> no pulse, busy returns low by cycle ~220, rx_data unchanged.
REQ-034 Byte 0x3C with stop bit driven 0 -> one frame_err pulse, no new_rx_data, rx_data retains its prior value.
REQ-035 rstn low for 3 cycles during bit 4 of 0xF0, then 0x81 sent -> no pulse for 0xF0, single pulse with rx_data=0x81.
REQ-036 Byte 0xFF followed by idle line for 5000 cycles -> exactly one pulse, rx_data=0xFF, busy low during idle.
